// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//   Multi-cycle multiply controller for the execute stage. It accepts one
//   operation per start handshake and processes one DIGIT-bit slice of the
//   multiplier per cycle, using shift-add accumulation on operand magnitudes.
//   It then applies sign correction and returns the full product and the
//   selected 32-bit word. Latency is WIDTH/DIGIT + 1 cycles from the accept
//   edge.
//
// Ports
//   i_clk            clock, all state changes on rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          request, sampled only while o_busy = 0
//   i_op             00 MUL, 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)
//   i_multiplicand   operand A (signed for MULH/MULHSU)
//   i_multiplier     operand B (signed for MULH)
//   o_busy           high from the accept edge until the result is registered
//   o_done           one-cycle pulse; o_result/o_product valid
//   o_result         low word for MUL, high word otherwise
//   o_product        full 2*WIDTH product under the opcode's signedness
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [1:0]           i_op,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_result,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SEL_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_op;
    logic                 r_sa;
    logic                 r_sb;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_result;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last_digit;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [SEL_W-1:0]     w_dsel;
    logic [DIGIT-1:0]     w_digit;
    logic [WIDTH+DIGIT-1:0] w_pp;
    logic [2*WIDTH-1:0]   w_pp_ext;
    logic [2*WIDTH-1:0]   w_fix_prod;

    // Sign flags and magnitudes of the incoming operands. The most-negative
    // value negates to itself, which is its correct unsigned magnitude.
    assign w_sa    = ((i_op == 2'b01) || (i_op == 2'b10)) && i_multiplicand[WIDTH-1];
    assign w_sb    = (i_op == 2'b01) && i_multiplier[WIDTH-1];
    assign w_mag_a = w_sa ? (~i_multiplicand + 1'b1) : i_multiplicand;
    assign w_mag_b = w_sb ? (~i_multiplier + 1'b1) : i_multiplier;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_last_digit = (r_cnt == CNT_W'(NDIG - 1));

    // One WIDTH x DIGIT partial product per cycle, placed at the digit's weight.
    assign w_dsel   = SEL_W'(r_cnt) * SEL_W'(DIGIT);
    assign w_digit  = r_mag_b[w_dsel +: DIGIT];
    assign w_pp     = {{DIGIT{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, w_digit};
    assign w_pp_ext = {{(WIDTH-DIGIT){1'b0}}, w_pp} << w_dsel;

    assign w_fix_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last_digit) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op    <= i_op;
                r_sa    <= w_sa;
                r_sb    <= w_sb;
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end
            if (r_state == S_CALC) begin
                r_acc <= r_acc + w_pp_ext;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_FIX) begin
                r_product <= w_fix_prod;
                r_result  <= (r_op == 2'b00) ? w_fix_prod[WIDTH-1:0]
                                             : w_fix_prod[2*WIDTH-1:WIDTH];
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_result  = r_result;
    assign o_product = r_product;

endmodule
